// File: rtl/wall_follower_ctrl.sv
// Left-hand wall-following navigation controller for the pipe-cleaner robot.
// Issues one-cycle move pulses on acao, tracks position and reports done/timeout/stuck.
module wall_follower_ctrl #(
  parameter int unsigned START_ROW    = 9,
  parameter int unsigned START_COL    = 17,
  parameter int unsigned ROWS         = 10,
  parameter int unsigned COLS         = 20,
  parameter logic [2:0]  START_ORIENT = 3'b001,
  parameter int unsigned SETTLE_CYC   = 1,
  parameter int unsigned MAX_STEPS    = 255,
  parameter int unsigned STEP_W       = 8
) (
  input  logic              clockc1,
  input  logic              reset,
  input  logic              go,
  input  logic              head,
  input  logic              left,
  output logic [2:0]        acao,
  output logic [2:0]        orientacao,
  output logic [3:0]        row_pos,
  output logic [4:0]        col_pos,
  output logic [STEP_W-1:0] step_cnt,
  output logic              done,
  output logic              timeout,
  output logic              stuck
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_DECIDE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    DIR_NONE = 3'b000,
    DIR_N    = 3'b001,
    DIR_W    = 3'b010,
    DIR_E    = 3'b011,
    DIR_S    = 3'b100
  } dir_e;

  function automatic dir_e turn_left(input dir_e d);
    case (d)
      DIR_N:   return DIR_W;
      DIR_W:   return DIR_S;
      DIR_S:   return DIR_E;
      DIR_E:   return DIR_N;
      default: return d;
    endcase
  endfunction

  function automatic dir_e turn_right(input dir_e d);
    case (d)
      DIR_N:   return DIR_E;
      DIR_E:   return DIR_S;
      DIR_S:   return DIR_W;
      DIR_W:   return DIR_N;
      default: return d;
    endcase
  endfunction

  state_e              r_state,   w_state_nxt;
  dir_e                r_orient,  w_orient_nxt;
  logic [2:0]          r_acao,    w_acao_nxt;
  logic [3:0]          r_row,     w_row_nxt;
  logic [4:0]          r_col,     w_col_nxt;
  logic [STEP_W-1:0]   r_step,    w_step_nxt;
  logic [SET_W-1:0]    r_settle,  w_settle_nxt;
  logic [2:0]          r_rturn,   w_rturn_nxt;
  logic                r_turned,  w_turned_nxt;
  logic                r_done,    w_done_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic                r_stuck,   w_stuck_nxt;

  logic                w_in_grid;
  logic [3:0]          w_row_mv;
  logic [4:0]          w_col_mv;
  logic                w_at_start;

  // Target cell of a move along the current heading; grid edges count as walls.
  always_comb begin
    w_in_grid = 1'b0;
    w_row_mv  = r_row;
    w_col_mv  = r_col;
    case (r_orient)
      DIR_N: begin
        w_in_grid = (r_row != 4'd0);
        w_row_mv  = r_row - 4'd1;
      end
      DIR_S: begin
        w_in_grid = (r_row != 4'(ROWS - 1));
        w_row_mv  = r_row + 4'd1;
      end
      DIR_W: begin
        w_in_grid = (r_col != 5'd0);
        w_col_mv  = r_col - 5'd1;
      end
      DIR_E: begin
        w_in_grid = (r_col != 5'(COLS - 1));
        w_col_mv  = r_col + 5'd1;
      end
      default: w_in_grid = 1'b0;
    endcase
  end

  assign w_at_start = (r_row == 4'(START_ROW)) && (r_col == 5'(START_COL));

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt   = r_state;
    w_orient_nxt  = r_orient;
    w_acao_nxt    = 3'b000;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_step_nxt    = r_step;
    w_settle_nxt  = r_settle;
    w_rturn_nxt   = r_rturn;
    w_turned_nxt  = r_turned;
    w_done_nxt    = r_done;
    w_timeout_nxt = r_timeout;
    w_stuck_nxt   = r_stuck;

    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = '0;
          w_step_nxt   = '0;
          w_turned_nxt = 1'b0;
          w_rturn_nxt  = 3'd0;
        end
      end

      // Sensor flags lag a new heading/command by one edge, so they are not looked at here.
      ST_SETTLE: begin
        if (r_settle == SET_W'(SETTLE_CYC - 1)) begin
          w_state_nxt = ST_DECIDE;
        end else begin
          w_settle_nxt = r_settle + SET_W'(1);
        end
      end

      ST_DECIDE: begin
        if (!left && !r_turned) begin
          w_orient_nxt = turn_left(r_orient);
          w_turned_nxt = 1'b1;
          w_rturn_nxt  = 3'd0;
          w_settle_nxt = '0;
          w_state_nxt  = ST_SETTLE;
        end else if (!head && w_in_grid) begin
          w_acao_nxt   = r_orient;
          w_row_nxt    = w_row_mv;
          w_col_nxt    = w_col_mv;
          w_step_nxt   = r_step + STEP_W'(1);
          w_turned_nxt = 1'b0;
          w_rturn_nxt  = 3'd0;
          w_state_nxt  = ST_CHECK;
        end else begin
          w_orient_nxt = turn_right(r_orient);
          w_turned_nxt = 1'b0;
          w_rturn_nxt  = r_rturn + 3'd1;
          if (r_rturn == 3'd3) begin
            w_done_nxt  = 1'b1;
            w_stuck_nxt = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_settle_nxt = '0;
            w_state_nxt  = ST_SETTLE;
          end
        end
      end

      // Returning to start takes precedence over hitting the step limit.
      ST_CHECK: begin
        if (w_at_start && (r_step != '0)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_step == STEP_W'(MAX_STEPS)) begin
          w_done_nxt    = 1'b1;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_DONE;
        end else begin
          w_settle_nxt = '0;
          w_state_nxt  = ST_SETTLE;
        end
      end

      ST_DONE: w_state_nxt = ST_DONE;

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clockc1 or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_orient  <= dir_e'(START_ORIENT);
      r_acao    <= 3'b000;
      r_row     <= 4'(START_ROW);
      r_col     <= 5'(START_COL);
      r_step    <= '0;
      r_settle  <= '0;
      r_rturn   <= 3'd0;
      r_turned  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_stuck   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_orient  <= w_orient_nxt;
      r_acao    <= w_acao_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_step    <= w_step_nxt;
      r_settle  <= w_settle_nxt;
      r_rturn   <= w_rturn_nxt;
      r_turned  <= w_turned_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
      r_stuck   <= w_stuck_nxt;
    end
  end

  assign acao       = r_acao;
  assign orientacao = r_orient;
  assign row_pos    = r_row;
  assign col_pos    = r_col;
  assign step_cnt   = r_step;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign stuck      = r_stuck;

endmodule

// File: doc/wall_follower_ctrl.md
Name: wall_follower_ctrl

Overview:
- Navigation controller for the pipe-cleaner robot, sitting directly upstream of the map/sensor stage.
- It consumes the one-bit head and left wall flags that the map stage produces. It issues single-cycle move commands (acao) and holds the heading (orientacao) that the map stage samples on clockc1.
- It runs a left-hand wall-following traversal with its own position tracking, and reports completion (returned to start), timeout, or stuck.

Parameters:
- START_ROW, 9, initial row index (0..ROWS-1)
- START_COL, 17, initial column cell index (cell, not nibble offset; map nibble offset = 4*col)
- ROWS, 10, grid rows
- COLS, 20, grid columns
- START_ORIENT, 3'b001, initial heading
- SETTLE_CYC, 1, idle cycles after any command before sensors are trusted (min 1)
- MAX_STEPS, 255, move count that forces timeout
- STEP_W, 8, width of step counter

Ports:
- clockc1 input 1 system clock, all state on rising edge
- reset input 1 asynchronous, active-high
- go input 1 start pulse, honoured only in IDLE
- head input 1 map wall flag ahead of current heading, 1 = blocked
- left input 1 map wall flag left of current heading, 1 = blocked
- acao output 3 move command, 000 = none, else one-cycle pulse
- orientacao output 3 current heading
- row_pos output 4 tracked row
- col_pos output 5 tracked column cell
- step_cnt output STEP_W moves issued since go
- done output 1 traversal finished (sticky)
- timeout output 1 finished by MAX_STEPS
- stuck output 1 finished by four consecutive right turns

Behaviour:
- Reset is asynchronous and active-high. Clock is clockc1.
- Encoding, shared with the map stage for both acao and orientacao: 001 N (row-1), 010 W (col-1), 011 E (col+1), 100 S (row+1). A move command always equals the current orientacao code.
- Left-turn table: N->W, W->S, S->E, E->N. Right-turn table: N->E, E->S, S->W, W->N.
- Reset values:
  - acao = 000; orientacao = START_ORIENT.
  - row_pos/col_pos = START_ROW/START_COL.
  - step_cnt = 0; done/timeout/stuck = 0.
  - turned_left = 0, rturn_cnt = 0, state = IDLE.
  - Reset is honoured mid-operation in any state, including during an acao pulse.
  - The map stage must be reinitialised by the system in the same reset.
- FSM states:
  - IDLE: acao = 000. On go -> SETTLE with settle counter cleared. step_cnt, turned_left and rturn_cnt are cleared on entry.
  - SETTLE: acao = 000. Counts SETTLE_CYC cycles, then -> DECIDE. head/left are ignored here, because the map updates them one edge after it samples a new acao/orientacao.
  - DECIDE: evaluated in priority order:
    - (a) left==0 and turned_left==0: orientacao <= left-turn; turned_left <= 1; rturn_cnt <= 0; -> SETTLE.
    - (b) head==0 and the move stays in-grid: acao <= orientacao for exactly one cycle; row/col updated the same edge; step_cnt +1; turned_left <= 0; rturn_cnt <= 0; -> CHECK.
    - (c) otherwise: orientacao <= right-turn; turned_left <= 0; rturn_cnt +1. If rturn_cnt becomes 4 -> DONE with stuck=1; else -> SETTLE.
  - CHECK: acao back to 000. Evaluated in priority order:
    - row/col == start and step_cnt != 0 -> DONE.
    - else step_cnt == MAX_STEPS -> DONE with timeout=1.
    - else -> SETTLE.
    - Start-return wins over timeout if both hold.
  - DONE: acao = 000, done = 1. All outputs hold until reset; go is ignored.
- A move is off-grid when row 0 heads N, row ROWS-1 heads S, col 0 heads W, or col COLS-1 heads E. An off-grid move is treated as blocked even if head==0; row/col never wrap.
- step_cnt never wraps; MAX_STEPS must be <= 2^STEP_W-1.
- Steady-state straight corridor: one move every SETTLE_CYC+2 cycles.
- acao is never nonzero on two consecutive cycles.
- orientacao changes only on the DECIDE edge.

Test Plan:
- Open corridor: go, SETTLE_CYC=1, head=0/left=1 constant, orient N -> acao=001 pulses every 3 cycles; row_pos 9,8,7...; step_cnt increments by 1 per pulse; col_pos stays 17.
- Left opening: at DECIDE head=0, left=0, orient N -> orientacao=010 with no acao. Next DECIDE with left=0 again -> acao=010 (turned_left suppresses a second turn); col_pos 16.
- Dead end: head=1/left=1 forever -> orientacao N->E->S->W->N across 4 DECIDEs; done=1 and stuck=1; step_cnt=0; acao never nonzero.
- Timeout: MAX_STEPS=4, open corridor -> after 4th pulse, done=1, timeout=1, step_cnt=4, row_pos=5.
- Loop closure: behavioural map stub giving a 2x2 room at start (turns forcing N,E,S,W moves) -> after 4th move row/col=9/17; done=1, timeout=0, stuck=0.
- Reset mid-pulse: assert reset on the cycle acao=001 -> acao=000, orientacao=001, row/col=9/17, step_cnt=0 immediately (asynchronous). A fresh go restarts from IDLE.
